// File: rtl/dmem_io_pkg.sv
// Shared address map, store-size encodings and decode types for the data
// memory / memory-mapped I/O block.
package dmem_io_pkg;

    localparam logic [31:0] ADDR_PORTA = 32'h0000_FF00;
    localparam logic [31:0] ADDR_EDGE  = 32'h0000_FF04;
    localparam logic [31:0] ADDR_PORTB = 32'h0000_FF10;
    localparam logic [31:0] ADDR_PORTC = 32'h0000_FF20;
    localparam logic [31:0] ADDR_PORTD = 32'h0000_FFFC;
    localparam logic [31:0] ADDR_TCNT  = 32'h0000_FF30;
    localparam logic [31:0] ADDR_TCMP  = 32'h0000_FF34;
    localparam logic [31:0] ADDR_TCTRL = 32'h0000_FF38;
    localparam logic [31:0] ADDR_TSTAT = 32'h0000_FF3C;

    localparam logic [1:0] WS_BYTE = 2'b00;
    localparam logic [1:0] WS_HALF = 2'b01;
    localparam logic [1:0] WS_WORD = 2'b10;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_PORTA,
        SEL_EDGE,
        SEL_PORTB,
        SEL_PORTC,
        SEL_PORTD,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TCTRL,
        SEL_TSTAT
    } sel_e;

    // Byte-lane enables for a RAM store; misaligned halves/words write nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] ws, input logic [1:0] lo);
        logic [3:0] m;
        case (ws)
            WS_BYTE: m = 4'b0001 << lo;
            WS_HALF: m = lo[0] ? 4'b0000 : (lo[1] ? 4'b1100 : 4'b0011);
            default: m = (lo == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop input synchroniser with a one-cycle rising-edge pulse taken
// from the synchronised value.
module io_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/dmem_io_mmio.sv
// Byte-addressable data RAM plus key/switch/display/LED ports and a cycle
// timer, all sharing one load/store port of the single-cycle core.
module dmem_io_mmio
    import dmem_io_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
    parameter int          PA_W        = 4,
    parameter int          PB_W        = 16,
    parameter int          PC_W        = 16,
    parameter int          PD_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [1:0]      wsize,
    input  logic [31:0]     a,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic [PA_W-1:0] porta_in,
    input  logic [PB_W-1:0] portb_in,
    output logic [PC_W-1:0] portc_out,
    output logic [PD_W-1:0] portd_out,
    output logic            timer_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0]   word_a;
    logic [31:0]   ram_off;
    sel_e          sel;
    logic          wr_en;
    logic          io_wr;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata;
    logic [AW-1:0] ram_idx;
    logic [7:0]    ram_rd_byte [4];

    logic [PA_W-1:0] pa_sync;
    logic [PA_W-1:0] pa_rise;
    logic [PB_W-1:0] pb_sync;
    logic [PB_W-1:0] pb_rise_unused;

    logic [PC_W-1:0] portc_q, portc_d;
    logic [PD_W-1:0] portd_q, portd_d;
    logic [PA_W-1:0] edge_q, edge_d, edge_clr;
    logic [31:0]     tcnt_q, tcnt_d;
    logic [31:0]     tcmp_q, tcmp_d;
    logic [1:0]      tctrl_q, tctrl_d;
    logic            tstat_q, tstat_d, tstat_clr;
    logic            tmatch;

    assign word_a  = {a[31:2], 2'b00};
    assign ram_off = word_a - RAM_BASE;
    assign ram_idx = a[AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (ram_off < RAM_BYTES) begin
            sel = SEL_RAM;
        end else begin
            case (word_a)
                ADDR_PORTA: sel = SEL_PORTA;
                ADDR_EDGE:  sel = SEL_EDGE;
                ADDR_PORTB: sel = SEL_PORTB;
                ADDR_PORTC: sel = SEL_PORTC;
                ADDR_PORTD: sel = SEL_PORTD;
                ADDR_TCNT:  sel = SEL_TCNT;
                ADDR_TCMP:  sel = SEL_TCMP;
                ADDR_TCTRL: sel = SEL_TCTRL;
                ADDR_TSTAT: sel = SEL_TSTAT;
                default:    sel = SEL_NONE;
            endcase
        end
    end

    // A store coincident with reset is dropped everywhere, RAM included.
    assign wr_en   = we & ~reset;
    assign io_wr   = wr_en & wsize[1];
    assign lane_we = (wr_en && sel == SEL_RAM) ? lane_mask(wsize, a[1:0]) : 4'b0000;

    always_comb begin
        case (wsize)
            WS_BYTE: lane_wdata = {4{wd[7:0]}};
            WS_HALF: lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    end

    // One byte-wide array per lane so each lane has a single writer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[ram_idx] <= lane_wdata[gi*8 +: 8];
                end
            end

            assign ram_rd_byte[gi] = lane_mem[ram_idx];
        end
    endgenerate

    io_sync_edge #(.W(PA_W)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .din   (porta_in),
        .dout  (pa_sync),
        .rise  (pa_rise)
    );

    io_sync_edge #(.W(PB_W)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .din   (portb_in),
        .dout  (pb_sync),
        .rise  (pb_rise_unused)
    );

    // Match uses the pre-increment count; new edges/matches beat a W1C.
    always_comb begin
        portc_d   = portc_q;
        portd_d   = portd_q;
        tcmp_d    = tcmp_q;
        tctrl_d   = tctrl_q;
        edge_clr  = '0;
        tstat_clr = 1'b0;
        tmatch    = tctrl_q[0] && (tcnt_q == tcmp_q);
        tcnt_d    = tctrl_q[0] ? tcnt_q + 32'd1 : tcnt_q;
        if (io_wr) begin
            case (sel)
                SEL_EDGE:  edge_clr  = wd[PA_W-1:0];
                SEL_PORTC: portc_d   = wd[PC_W-1:0];
                SEL_PORTD: portd_d   = wd[PD_W-1:0];
                SEL_TCNT:  tcnt_d    = wd;
                SEL_TCMP:  tcmp_d    = wd;
                SEL_TCTRL: tctrl_d   = wd[1:0];
                SEL_TSTAT: tstat_clr = wd[0];
                default:   ;
            endcase
        end
        edge_d  = (edge_q & ~edge_clr) | pa_rise;
        tstat_d = (tstat_q & ~tstat_clr) | tmatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            portc_q <= '0;
            portd_q <= '0;
            edge_q  <= '0;
            tcnt_q  <= '0;
            tcmp_q  <= '0;
            tctrl_q <= '0;
            tstat_q <= 1'b0;
        end else begin
            portc_q <= portc_d;
            portd_q <= portd_d;
            edge_q  <= edge_d;
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tctrl_q <= tctrl_d;
            tstat_q <= tstat_d;
        end
    end

    always_comb begin
        rd = '0;
        case (sel)
            SEL_RAM:   rd = {ram_rd_byte[3], ram_rd_byte[2], ram_rd_byte[1], ram_rd_byte[0]};
            SEL_PORTA: rd[PA_W-1:0] = pa_sync;
            SEL_EDGE:  rd[PA_W-1:0] = edge_q;
            SEL_PORTB: rd[PB_W-1:0] = pb_sync;
            SEL_PORTC: rd[PC_W-1:0] = portc_q;
            SEL_PORTD: rd[PD_W-1:0] = portd_q;
            SEL_TCNT:  rd = tcnt_q;
            SEL_TCMP:  rd = tcmp_q;
            SEL_TCTRL: rd[1:0] = tctrl_q;
            SEL_TSTAT: rd[0] = tstat_q;
            default:   rd = '0;
        endcase
    end

    assign portc_out = portc_q;
    assign portd_out = portd_q;
    assign timer_irq = tstat_q & tctrl_q[1];

endmodule

// File: tb/tb_dmem_io_mmio.sv
// Randomised bench for dmem_io_mmio: a byte-level memory / register model
// predicts every load and output, with directed scenarios up front.
module tb_dmem_io_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [1:0]  wsize;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  porta_in;
    logic [15:0] portb_in;
    logic [15:0] portc_out;
    logic [15:0] portd_out;
    logic        timer_irq;

    always #5 clk = ~clk;

    dmem_io_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .wsize     (wsize),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .porta_in  (porta_in),
        .portb_in  (portb_in),
        .portc_out (portc_out),
        .portd_out (portd_out),
        .timer_irq (timer_irq)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int txn_cnt = 0;
    logic [31:0] last_rd;

    // Reference state: RAM as a flat byte array, pin history per port.
    logic [7:0]  ram_m [256];
    logic [15:0] pc_m, pd_m;
    logic [3:0]  edge_m;
    logic [31:0] cnt_m, cmp_m;
    logic [1:0]  ctrl_m;
    logic        stat_m;
    logic [3:0]  ha [$];
    logic [15:0] hb [$];

    logic [31:0] io_addrs [9] = '{32'hFF00, 32'hFF04, 32'hFF10, 32'hFF20, 32'hFFFC,
                                  32'hFF30, 32'hFF34, 32'hFF38, 32'hFF3C};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pc_m = '0; pd_m = '0; edge_m = '0;
        cnt_m = '0; cmp_m = '0; ctrl_m = '0; stat_m = 1'b0;
        ha.delete(); hb.delete();
        for (int i = 0; i < 4; i++) begin
            ha.push_back(4'h0);
            hb.push_back(16'h0);
        end
    endtask

    // Synced value = pin sampled one edge before the latest; an edge bit
    // sets when that synced value went 0->1 on the edge before.
    function automatic logic [31:0] model_rd(input logic [31:0] ad);
        logic [31:0] wa;
        logic [31:0] off;
        logic [7:0]  ob;
        wa  = ad & ~32'h3;
        off = wa - 32'h1000;
        ob  = off[7:0];
        if (off < 32'd256)
            return {ram_m[ob + 8'd3], ram_m[ob + 8'd2], ram_m[ob + 8'd1], ram_m[ob]};
        case (wa)
            32'hFF00: return {28'h0, ha[$-1]};
            32'hFF04: return {28'h0, edge_m};
            32'hFF10: return {16'h0, hb[$-1]};
            32'hFF20: return {16'h0, pc_m};
            32'hFFFC: return {16'h0, pd_m};
            32'hFF30: return cnt_m;
            32'hFF34: return cmp_m;
            32'hFF38: return {30'h0, ctrl_m};
            32'hFF3C: return {31'h0, stat_m};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_clk(input logic w, input logic [1:0] ws, input logic [31:0] ad,
                             input logic [31:0] d, input logic rst,
                             input logic [3:0] pa, input logic [15:0] pb);
        logic [31:0] wa, off, nc;
        logic [7:0]  b;
        logic [3:0]  rise, eclr;
        logic        match, sclr;
        if (rst) begin
            model_reset();
            return;
        end
        ha.push_back(pa);
        hb.push_back(pb);
        if (ha.size() > 8) void'(ha.pop_front());
        if (hb.size() > 8) void'(hb.pop_front());
        rise  = ha[$-2] & ~ha[$-3];
        match = ctrl_m[0] && (cnt_m == cmp_m);
        nc    = ctrl_m[0] ? cnt_m + 32'd1 : cnt_m;
        eclr  = '0;
        sclr  = 1'b0;
        wa    = ad & ~32'h3;
        off   = wa - 32'h1000;
        b     = 8'(ad - 32'h1000);
        if (w) begin
            if (off < 32'd256) begin
                if (ws == 2'b00) begin
                    ram_m[b] = d[7:0];
                end else if (ws == 2'b01) begin
                    if (!ad[0]) begin
                        ram_m[b] = d[7:0];
                        ram_m[b + 8'd1] = d[15:8];
                    end
                end else if (ad[1:0] == 2'b00) begin
                    for (int k = 0; k < 4; k++) ram_m[b + 8'(k)] = d[k*8 +: 8];
                end
            end else if (ws[1]) begin
                case (wa)
                    32'hFF04: eclr   = d[3:0];
                    32'hFF20: pc_m   = d[15:0];
                    32'hFFFC: pd_m   = d[15:0];
                    32'hFF30: nc     = d;
                    32'hFF34: cmp_m  = d;
                    32'hFF38: ctrl_m = d[1:0];
                    32'hFF3C: sclr   = d[0];
                    default: ;
                endcase
            end
        end
        cnt_m  = nc;
        edge_m = (edge_m & ~eclr) | rise;
        stat_m = (stat_m & ~sclr) | match;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic w, input logic [1:0] ws, input logic [31:0] ad, input logic [31:0] d);
        we = w; wsize = ws; a = ad; wd = d;
        #1;
        last_rd = rd;
        check("rd", rd, model_rd(ad));
        $display("txn %0d rst=%0d we=%0d ws=%0d a=%h wd=%h rd=%h pa=%h pb=%h",
                 txn_cnt, reset, w, ws, ad, d, rd, porta_in, portb_in);
        txn_cnt++;
        @(posedge clk);
        model_clk(w, ws, ad, d, reset, porta_in, portb_in);
        #1;
        check("portc", 32'(portc_out), 32'(pc_m));
        check("portd", 32'(portd_out), 32'(pd_m));
        check("irq", 32'(timer_irq), 32'(stat_m & ctrl_m[1]));
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic irq_seen;
        int   sel;
        logic [31:0] ad;

        reset = 1'b1; we = 1'b0; wsize = 2'b10; a = '0; wd = '0;
        porta_in = '0; portb_in = '0;
        model_reset();
        @(negedge clk);
        cycle(0, 2'b10, 32'h0, 32'h0);
        cycle(0, 2'b10, 32'h0, 32'h0);
        check("rst_portc", 32'(portc_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) cycle(1, 2'b10, 32'h1000 + 32'(4*i), $urandom);

        // Byte lane merge and misaligned half suppression
        cycle(1, 2'b10, 32'h1004, 32'hDEADBEEF);
        cycle(1, 2'b00, 32'h1006, 32'h0000_0055);
        cycle(0, 2'b10, 32'h1004, 32'h0);
        check("sb_merge", last_rd, 32'hDE55BEEF);
        cycle(1, 2'b01, 32'h1005, 32'h0000_AAAA);
        cycle(0, 2'b10, 32'h1004, 32'h0);
        check("sh_misalign", last_rd, 32'hDE55BEEF);

        // Display register and unmapped read
        cycle(1, 2'b10, 32'hFF20, 32'h0000_04D2);
        check("portc_wr", 32'(portc_out), 32'h04D2);
        cycle(0, 2'b10, 32'hFF20, 32'h0);
        check("portc_rd", last_rd, 32'h0000_04D2);
        cycle(0, 2'b10, 32'h2000, 32'h0);
        check("unmapped", last_rd, 32'h0);

        // Switch synchroniser latency
        portb_in = 16'h1234;
        cycle(0, 2'b10, 32'hFF10, 32'h0);
        check("pb_c0", last_rd, 32'h0);
        cycle(0, 2'b10, 32'hFF10, 32'h0);
        check("pb_c1", last_rd, 32'h0);
        cycle(0, 2'b10, 32'hFF10, 32'h0);
        check("pb_c2", last_rd, 32'h1234);

        // Key edge capture, W1C, and set beating a coincident clear
        porta_in = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 2'b10, 32'hFF04, 32'h0);
            check("edge_lat", last_rd, (k == 3) ? 32'h4 : 32'h0);
        end
        cycle(1, 2'b10, 32'hFF04, 32'h4);
        cycle(0, 2'b10, 32'hFF04, 32'h0);
        check("edge_w1c", last_rd, 32'h0);
        porta_in = 4'b0000;
        repeat (3) cycle(0, 2'b10, 32'hFF04, 32'h0);
        porta_in = 4'b0100;
        cycle(0, 2'b10, 32'hFF04, 32'h0);
        cycle(0, 2'b10, 32'hFF04, 32'h0);
        cycle(1, 2'b10, 32'hFF04, 32'h4);
        cycle(0, 2'b10, 32'hFF04, 32'h0);
        check("edge_setwins", last_rd, 32'h4);

        // Timer compare, irq, W1C and wrap
        cycle(1, 2'b10, 32'hFF34, 32'd10);
        cycle(1, 2'b10, 32'hFF30, 32'd0);
        cycle(1, 2'b10, 32'hFF38, 32'd3);
        irq_seen = 1'b0;
        for (int k = 0; k < 40 && !irq_seen; k++) begin
            cycle(0, 2'b10, 32'hFF3C, 32'h0);
            irq_seen = timer_irq;
        end
        check("irq_set", 32'(irq_seen), 32'h1);
        cycle(1, 2'b10, 32'hFF3C, 32'h1);
        check("irq_clr", 32'(timer_irq), 32'h0);
        cycle(1, 2'b10, 32'hFF30, 32'hFFFF_FFFF);
        cycle(0, 2'b10, 32'hFF30, 32'h0);
        check("cnt_max", last_rd, 32'hFFFF_FFFF);
        cycle(0, 2'b10, 32'hFF30, 32'h0);
        check("cnt_wrap", last_rd, 32'h0);

        // Reset during activity with a store pending
        cycle(1, 2'b10, 32'hFF20, 32'h0000_BEEF);
        cycle(1, 2'b10, 32'hFFFC, 32'h0000_5A5A);
        reset = 1'b1;
        cycle(1, 2'b10, 32'h1004, 32'h1111_1111);
        reset = 1'b0;
        check("rst_mid_portc", 32'(portc_out), 32'h0);
        check("rst_mid_portd", 32'(portd_out), 32'h0);
        cycle(0, 2'b10, 32'hFF30, 32'h0);
        check("rst_mid_cnt", last_rd, 32'h0);
        cycle(0, 2'b10, 32'h1004, 32'h0);
        check("ram_kept", last_rd, 32'hDE55BEEF);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) porta_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) portb_in = 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)       ad = 32'h1000 + 32'($urandom_range(0, 255));
            else if (sel == 4) ad = $urandom;
            else               ad = io_addrs[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ad,
                  $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)));
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_io_mmio.md
Name: dmem_io_mmio

Overview:
Parametrised data memory plus memory-mapped I/O for the single-cycle RISC-V core, replacing the fixed 16-word, word-only, unsynchronised dmem/IO block. It adds byte/halfword write lanes and a configurable RAM depth and port widths. Inputs pass through a synchroniser with sticky rising-edge capture on porta (keys), and a 32-bit cycle timer with compare flag and IRQ is included. Sits between core load/store datapath and board switches/keys/7-seg driver.

Parameters:
DEPTH_WORDS, 64, RAM depth in 32-bit words (power of 2, 4..1024)
RAM_BASE, 32'h0000_1000, RAM base byte address; RAM spans RAM_BASE .. RAM_BASE+4*DEPTH_WORDS-1
PA_W, 4, porta width (keys), 1..32
PB_W, 16, portb width (switches), 1..32
PC_W, 16, portc width (display value), 1..32
PD_W, 16, portd width (LEDs), 1..32

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
we  in  1  store strobe from core
wsize  in  2  store size: 00 byte, 01 half, 10 word, 11 treated as word
a  in  32  byte address
wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rd  out  32  load data, full aligned word, combinational from a
porta_in  in  PA_W  asynchronous keys
portb_in  in  PB_W  asynchronous switches
portc_out  out  PC_W  display value register
portd_out  out  PD_W  LED register
timer_irq  out  1  timer status[0] AND ctrl[1]

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset: portc/portd regs, sync flops, edge register, timer count/compare/ctrl/status all 0; timer_irq 0. RAM contents not reset.
- Address map (word-aligned, a[1:0] ignored for decode): RAM range; 0xFF00 porta (sync, RO); 0xFF04 edge capture (R, W1C); 0xFF10 portb (sync, RO); 0xFF20 portc (RW); 0xFFFC portd (RW); 0xFF30 timer count (RW); 0xFF34 compare (RW); 0xFF38 ctrl (bit0 enable, bit1 irq enable, RW); 0xFF3C status (bit0 match, W1C).
- Reads: combinational, zero-extended to 32 bits; unmapped addresses return 0. RAM index = a[log2(DEPTH_WORDS)+1:2].
- Writes to RAM: byte lanes from wsize and a[1:0]: byte -> lane a[1:0] gets wd[7:0]; half -> lanes {a[1],0} pair get wd[15:0], suppressed if a[0]=1; word -> all lanes, suppressed if a[1:0]!=0. IO registers accept word writes only (lower PC_W/PD_W bits); sub-word stores to IO are ignored.
- Synchroniser: porta and portb pass through 2 flops; read value lags pin by 2 cycles. Edge bit i set the cycle after synced porta[i] goes 0->1 (3 cycles after pin). Simultaneous set and W1C on same bit: set wins.
- Timer: when ctrl[0]=1, count increments by 1 per cycle, wraps 0xFFFF_FFFF->0. CPU write to count wins over increment that cycle. status[0] set when enabled and count==compare (checked on pre-increment value); sticky until W1C; set wins over simultaneous clear. timer_irq combinational from registers.
- Reset asserted mid-operation: all registers above return to reset values next edge; a store in the same cycle is discarded.

Decomposition:
- Package dmem_io_pkg: address constants (ADDR_PORTA, ADDR_EDGE, ADDR_PORTB, ADDR_PORTC, ADDR_PORTD, ADDR_TCNT, ADDR_TCMP, ADDR_TCTRL, ADDR_TSTAT), wsize encodings (WS_BYTE, WS_HALF, WS_WORD).
- Sub-module io_sync_edge (param W): 2-flop synchroniser, previous-value flop, rising-edge pulse output; instanced for porta (edge used) and portb (edge unused).

Test Plan:
- reset; sw word 0xDEADBEEF to 0x1004; sb 0x55 at 0x1006 -> read 0x1004 = 0xDE55BEEF; sh at 0x1005 -> word unchanged.
- Store 0x0000_04D2 to 0xFF20 -> portc_out = 0x04D2 next edge; read 0xFF20 = 0x0000_04D2; read 0x2000 -> 0.
- portb_in 0x1234 at cycle 0 -> read 0xFF10 = 0x1234 from cycle 2, old value at cycle 1.
- porta_in[2] 0->1 -> read 0xFF04 = 0x4 after 3 cycles; W1C 0x4 -> 0; new edge coincident with W1C -> bit remains 1.
- compare=10, ctrl=3, count=0 -> status[0] and timer_irq high after count reaches 10; W1C status -> irq low; count=0xFFFF_FFFF wraps to 0.
- Assert reset during enabled timer and pending store -> count, status, portc/portd 0 next edge; RAM word from earlier test retained.
